// File: rtl/pe_result_collector_if.sv
// Bundle of dispatch, PE-return and result-word signals for the PE result collector.
interface pe_result_collector_if;
  localparam int unsigned NUM_PE = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned RES_W  = 12;

  logic                       disp_valid;
  logic [ID_W-1:0]            disp_pe;
  logic                       disp_ready;
  logic [NUM_PE-1:0]          pe_valid;
  logic [NUM_PE*DATA_W-1:0]   pe_data;
  logic [NUM_PE-1:0]          pe_ready;
  logic                       res_valid;
  logic [RES_W-1:0]           res_data;
  logic                       res_ready;
  logic                       err_orphan;

  modport slave (
    input  disp_valid, disp_pe, pe_valid, pe_data, res_ready,
    output disp_ready, pe_ready, res_valid, res_data, err_orphan
  );

  modport master (
    output disp_valid, disp_pe, pe_valid, pe_data, res_ready,
    input  disp_ready, pe_ready, res_valid, res_data, err_orphan
  );
endinterface

// File: rtl/pe_result_collector.sv
// Collects per-PE results into one-entry slots and retires them in dispatch order
// as {seq, 2'b00, pe_id, data} words over a valid/ready output.
module pe_result_collector (
  input  logic                  clock,
  input  logic                  reset,
  pe_result_collector_if.slave  bus
);
  localparam int unsigned NUM_PE = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned FIFO_D = 4;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SEQ_W  = 4;
  localparam int unsigned RES_W  = 12;

  logic [FIFO_D-1:0][ID_W-1:0]   fifo_q, fifo_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic [NUM_PE-1:0]             slot_full_q, slot_full_d;
  logic [NUM_PE-1:0][DATA_W-1:0] slot_q, slot_d;
  logic [NUM_PE-1:0][CNT_W-1:0]  outst_q, outst_d;
  logic [SEQ_W-1:0]              seq_q, seq_d;
  logic                          res_valid_q, res_valid_d;
  logic [RES_W-1:0]              res_data_q, res_data_d;
  logic                          err_orphan_q, err_orphan_d;

  logic [ID_W-1:0] head;
  logic            push;
  logic            retire;
  logic            inc;
  logic            dec;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fifo_q       <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      slot_full_q  <= '0;
      slot_q       <= '0;
      outst_q      <= '0;
      seq_q        <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      slot_full_q  <= slot_full_d;
      slot_q       <= slot_d;
      outst_q      <= outst_d;
      seq_q        <= seq_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      err_orphan_q <= err_orphan_d;
    end
  end

  always_comb begin
    fifo_d       = fifo_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    slot_full_d  = slot_full_q;
    slot_d       = slot_q;
    outst_d      = outst_q;
    seq_d        = seq_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    err_orphan_d = err_orphan_q;
    inc          = 1'b0;
    dec          = 1'b0;

    head   = fifo_q[rd_ptr_q];
    // Full FIFO refuses a push even if the head pops this cycle.
    push   = bus.disp_valid && (count_q < CNT_W'(FIFO_D));
    retire = (count_q != '0) && slot_full_q[head] && (!res_valid_q || bus.res_ready);

    if (push) begin
      fifo_d[wr_ptr_q] = bus.disp_pe;
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
    end

    if (retire) begin
      rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      res_valid_d = 1'b1;
      res_data_d  = {seq_q, 2'b00, head, slot_q[head]};
      seq_d       = seq_q + SEQ_W'(1);
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end

    case ({push, retire})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Slot write needs empty and clear needs full, so the two never collide.
    for (int i = 0; i < NUM_PE; i++) begin
      inc = push && (bus.disp_pe == ID_W'(i));
      dec = retire && (head == ID_W'(i));
      outst_d[i] = outst_q[i] + CNT_W'(inc) - CNT_W'(dec);
      if (bus.pe_valid[i] && !slot_full_q[i]) begin
        if (outst_q[i] != '0) begin
          slot_d[i]      = bus.pe_data[i*DATA_W +: DATA_W];
          slot_full_d[i] = 1'b1;
        end else begin
          err_orphan_d = 1'b1;
        end
      end
      if (dec) begin
        slot_full_d[i] = 1'b0;
      end
    end
  end

  assign bus.disp_ready = (count_q < CNT_W'(FIFO_D));
  assign bus.pe_ready   = ~slot_full_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.err_orphan = err_orphan_q;
endmodule

// File: tb/tb_pe_result_collector.sv
// Scoreboard bench for pe_result_collector: directed stimulus pushes expected words,
// a negedge monitor pops and compares every accepted result word.
module tb_pe_result_collector;
  logic clock;
  logic reset;
  int   tests;
  int   fails;
  logic [11:0] exp_q[$];

  pe_result_collector_if bus();

  pe_result_collector dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] w(input int s, input int pe, input int d);
    return {4'(s), 2'b00, 2'(pe), 4'(d)};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic dispatch(input int pe);
    bus.disp_valid = 1'b1;
    bus.disp_pe    = 2'(pe);
    step();
    bus.disp_valid = 1'b0;
  endtask

  task automatic pe_ret(input int pe, input logic [3:0] d);
    bit done;
    done = 1'b0;
    bus.pe_data[pe*4 +: 4] = d;
    bus.pe_valid[pe]       = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clock);
      if (bus.pe_ready[pe]) done = 1'b1;
      step();
    end
    bus.pe_valid[pe] = 1'b0;
    check("pe_accept", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Monitor: every accepted word must match the scoreboard head.
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clock);
      if (!reset && bus.res_valid && bus.res_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("[TB] FAIL unexpected_word: got %0h expected none at %0t", bus.res_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("res_word", 32'(bus.res_data), 32'(e));
        end
      end
    end
  end

  initial begin
    tests          = 0;
    fails          = 0;
    reset          = 1'b1;
    bus.disp_valid = 1'b0;
    bus.disp_pe    = 2'd0;
    bus.pe_valid   = 4'h0;
    bus.pe_data    = 16'h0;
    bus.res_ready  = 1'b1;

    // 1 reset values
    #3;
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_res_data", 32'(bus.res_data), 32'd0);
    check("rst_pe_ready", 32'(bus.pe_ready), 32'hF);
    check("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
    check("rst_err_orphan", 32'(bus.err_orphan), 32'd0);
    step();
    reset = 1'b0;
    step();

    // 2 in-order retire
    exp_q.push_back(12'h005);
    exp_q.push_back(12'h116);
    exp_q.push_back(12'h227);
    exp_q.push_back(12'h338);
    for (int p = 0; p < 4; p++) dispatch(p);
    for (int p = 0; p < 4; p++) pe_ret(p, 4'(p + 5));
    drain();

    // 3 out-of-order return
    do_reset();
    exp_q.push_back(12'h003);
    exp_q.push_back(12'h119);
    dispatch(0);
    dispatch(1);
    pe_ret(1, 4'h9);
    check("ooo_pe1_blocked", 32'(bus.pe_ready[1]), 32'd0);
    check("ooo_no_word", 32'(bus.res_valid), 32'd0);
    step();
    check("ooo_pe1_blocked2", 32'(bus.pe_ready[1]), 32'd0);
    pe_ret(0, 4'h3);
    drain();

    // 4 backpressure
    do_reset();
    bus.res_ready = 1'b0;
    exp_q.push_back(12'h001);
    exp_q.push_back(12'h112);
    dispatch(0);
    dispatch(1);
    pe_ret(0, 4'h1);
    pe_ret(1, 4'h2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("bp_hold_valid", 32'(bus.res_valid), 32'd1);
      check("bp_hold_data", 32'(bus.res_data), 32'h001);
      @(posedge clock);
    end
    #1;
    bus.res_ready = 1'b1;
    step();
    check("bp_b2b_valid", 32'(bus.res_valid), 32'd1);
    check("bp_b2b_data", 32'(bus.res_data), 32'h112);
    drain();

    // 5 FIFO full
    do_reset();
    exp_q.push_back(w(0, 0, 4'hA));
    exp_q.push_back(w(1, 1, 4'hB));
    exp_q.push_back(w(2, 2, 4'hC));
    exp_q.push_back(w(3, 3, 4'hD));
    exp_q.push_back(w(4, 3, 4'hE));
    exp_q.push_back(w(5, 0, 4'hF));
    for (int p = 0; p < 4; p++) dispatch(p);
    check("full_disp_ready", 32'(bus.disp_ready), 32'd0);
    dispatch(0);
    check("full_refused", 32'(bus.disp_ready), 32'd0);
    pe_ret(0, 4'hA);
    dispatch(2);
    check("full_pop_refuse", 32'(bus.disp_ready), 32'd1);
    pe_ret(1, 4'hB);
    dispatch(3);
    check("pushpop_count", 32'(bus.disp_ready), 32'd1);
    dispatch(0);
    check("refill_full", 32'(bus.disp_ready), 32'd0);
    pe_ret(2, 4'hC);
    pe_ret(3, 4'hD);
    pe_ret(3, 4'hE);
    pe_ret(0, 4'hF);
    drain();

    // 6a orphan result
    do_reset();
    pe_ret(2, 4'h5);
    check("orphan_set", 32'(bus.err_orphan), 32'd1);
    check("orphan_dropped", 32'(bus.pe_ready), 32'hF);
    for (int c = 0; c < 4; c++) step();
    check("orphan_sticky", 32'(bus.err_orphan), 32'd1);
    check("orphan_no_word", 32'(bus.res_valid), 32'd0);

    // 6b sequence wrap over 17 retires
    for (int k = 0; k < 17; k++) begin
      exp_q.push_back(w(k, k % 4, (k ^ 5) & 15));
      dispatch(k % 4);
      pe_ret(k % 4, 4'((k ^ 5) & 15));
    end
    drain();
    check("orphan_end", 32'(bus.err_orphan), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
